cd_rx_drain: RTL and testbench
==============================

// Module: cd_rx_drain
// PURPOSE
//  Autonomous CSR master sitting directly downstream of the cdbus top: replaces host polling by draining received
//  frames out of the cdbus CSR interface and presenting them as a 32-bit word stream with SOP/EOP framing.
//  Detects a pending RX frame (irq or periodic poll), reads its length, reads ceil(len/4) data words, releases
//  the RX buffer, then waits for the next frame. Connects to cdbus csr_* ports; out_* feeds a FIFO/DMA.
// PARAMETERS
//  ADDR_STATUS   4'd2     CSR word address of the status register
//  ADDR_RX_LEN   4'd6     CSR address of RX frame length; bits [7:0] = byte count (0..255)
//  ADDR_RX_DATA  4'd7     CSR address of RX data; each read returns next 4 bytes, little-endian, auto-increment
//  ADDR_RX_CTRL  4'd8     CSR address of the RX control register
//  PEND_BIT      1        status bit index meaning "RX frame pending"
//  DONE_VAL      32'h2    value written to ADDR_RX_CTRL to release the current RX buffer
//  POLL_DIV      1024     clocks between status polls when irq is low; 0 disables polling
// PORTS
//  clk           in   1   clock
//  reset         in   1   asynchronous, active-high reset
//  enable        in   1   1 = start new frames; 0 = finish current frame then stay idle
//  irq           in   1   cdbus interrupt; level, triggers immediate status read
//  csr_address   out  4   to cdbus
//  csr_read      out  1   one-cycle read strobe; readdata valid exactly 1 cycle later
//  csr_readdata  in   32  from cdbus
//  csr_write     out  1   one-cycle write strobe
//  csr_writedata out  32  write data
//  out_data      out  32  frame word, byte 0 in [7:0]
//  out_valid     out  1   word valid; held with data stable until out_ready
//  out_ready     in   1   consumer accepts when out_valid && out_ready
//  out_sop       out  1   first word of frame (qualified by out_valid)
//  out_eop       out  1   last word of frame (qualified by out_valid)
//  out_bytes     out  3   valid bytes in word: 4 except on EOP, where 1..4 (len%4, 0 -> 4)
//  frame_cnt     out  16  frames completed (DONE written), wraps 16'hFFFF -> 0
//  busy          out  1   state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, poll counter 0, frame_cnt 0. Reset mid-frame aborts silently; the cdbus
//   buffer is NOT released and is re-read from word 0 (after the host clears cdbus) - documented limitation.
//  FSM: IDLE -> ST_RD -> ST_WT -> (pending ? LEN_RD : IDLE) -> LEN_WT -> (len==0 ? DONE : DAT_RD)
//   DAT_RD -> DAT_WT -> PUSH -> (words_left ? DAT_RD : DONE) ; DONE -> IDLE.
//  IDLE leaves when enable && (irq || poll_cnt==POLL_DIV-1); poll_cnt counts only in IDLE, clears on exit.
//  *_RD states: assert csr_read + address for exactly 1 cycle. *_WT: capture csr_readdata.
//  words = (len+3)>>2 (9-bit arith, max 64). SOP on first word, EOP when words_left==1 after capture.
//  PUSH: out_valid=1; next CSR read issued only after handshake, so at most one word in flight, no data loss.
//   Peak throughput 1 word / 3 clk with out_ready held high.
//  DONE: csr_write=1, address ADDR_RX_CTRL, writedata DONE_VAL for 1 cycle; frame_cnt++ same cycle.
//  csr_read and csr_write never asserted together; csr outputs 0 in all other states.
//  enable low in any non-IDLE state: ignored until frame completes (DONE). enable low in IDLE: stay IDLE.
//  irq high while busy: ignored; after DONE status is re-read (irq stays high while frames queued).
//  Status pending=0 (spurious irq/poll): back to IDLE, nothing pushed, frame_cnt unchanged.
//  len==0: no output words, buffer still released, frame_cnt increments.
// STRUCTURE
//  Shared package cd_pkg: state enum, CSR address/bit defaults, DONE_VAL constant.
//  Single module; no sub-module (poll counter and word counter are inline).
// TESTING
//  len=5, data 0x44332211,0x00000055, ready=1 -> 2 words, SOP on 1st, EOP on 2nd with out_bytes=1, DONE written, frame_cnt=1.
//  len=8, out_ready low for 20 clk on word 0 -> out_valid/out_data held stable; no csr_read during stall; 2 words total.
//  irq=0, POLL_DIV=16, pending set at clk 5 -> status read at clk 16 after reset release; frame drained.
//  Status pending=0 on irq glitch -> return IDLE, no out_valid, no csr_write, frame_cnt=0.
//  len=0 -> zero output words, one DONE write, frame_cnt=1; len=255 -> 64 words, EOP out_bytes=3.
//  Reset asserted during DAT_WT of word 3 -> all outputs 0 next edge; enable drop mid-frame -> frame completes, then IDLE.

Source files
------------

// File: rtl/cd_pkg.sv
// Shared types and defaults for the cdbus RX drain engine.
package cd_pkg;

   localparam int unsigned CSR_AW  = 4;
   localparam int unsigned CSR_DW  = 32;
   localparam int unsigned LEN_W   = 8;
   localparam int unsigned WCNT_W  = 7;
   localparam int unsigned BYTES_W = 3;
   localparam int unsigned FCNT_W  = 16;

   localparam logic [CSR_AW-1:0] ADDR_STATUS_DEF  = 4'd2;
   localparam logic [CSR_AW-1:0] ADDR_RX_LEN_DEF  = 4'd6;
   localparam logic [CSR_AW-1:0] ADDR_RX_DATA_DEF = 4'd7;
   localparam logic [CSR_AW-1:0] ADDR_RX_CTRL_DEF = 4'd8;
   localparam int unsigned       PEND_BIT_DEF     = 1;
   localparam logic [CSR_DW-1:0] DONE_VAL_DEF     = 32'h2;
   localparam int unsigned       POLL_DIV_DEF     = 1024;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ST_RD,
      S_ST_WT,
      S_LEN_RD,
      S_LEN_WT,
      S_DAT_RD,
      S_DAT_WT,
      S_PUSH,
      S_DONE
   } state_e;

   // Number of 32-bit words holding len bytes; 9-bit sum so 255 does not wrap.
   function automatic logic [WCNT_W-1:0] words_of(input logic [LEN_W-1:0] len);
      logic [8:0] t;
      t = 9'(len) + 9'd3;
      return WCNT_W'(t >> 2);
   endfunction

   // Valid bytes in the final word: len mod 4, with 0 meaning a full word.
   function automatic logic [BYTES_W-1:0] last_bytes(input logic [LEN_W-1:0] len);
      return (len[1:0] == 2'd0) ? 3'd4 : {1'b0, len[1:0]};
   endfunction

endpackage

// File: rtl/cd_rx_drain.sv
// Autonomous CSR master: drains cdbus RX frames into a 32-bit word stream
// with SOP/EOP framing, then releases the RX buffer.
module cd_rx_drain
   import cd_pkg::*;
#(
   parameter logic [CSR_AW-1:0] ADDR_STATUS  = ADDR_STATUS_DEF,
   parameter logic [CSR_AW-1:0] ADDR_RX_LEN  = ADDR_RX_LEN_DEF,
   parameter logic [CSR_AW-1:0] ADDR_RX_DATA = ADDR_RX_DATA_DEF,
   parameter logic [CSR_AW-1:0] ADDR_RX_CTRL = ADDR_RX_CTRL_DEF,
   parameter int unsigned       PEND_BIT     = PEND_BIT_DEF,
   parameter logic [CSR_DW-1:0] DONE_VAL     = DONE_VAL_DEF,
   parameter int unsigned       POLL_DIV     = POLL_DIV_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                irq,
   output logic [CSR_AW-1:0]   csr_address,
   output logic                csr_read,
   input  logic [CSR_DW-1:0]   csr_readdata,
   output logic                csr_write,
   output logic [CSR_DW-1:0]   csr_writedata,
   output logic [CSR_DW-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_sop,
   output logic                out_eop,
   output logic [BYTES_W-1:0]  out_bytes,
   output logic [FCNT_W-1:0]   frame_cnt,
   output logic                busy
);

   localparam int unsigned POLL_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

   state_e              state_q, state_d;
   logic [POLL_W-1:0]   poll_q, poll_d;
   logic [WCNT_W-1:0]   words_left_q, words_left_d;
   logic [BYTES_W-1:0]  last_bytes_q, last_bytes_d;
   logic                first_q, first_d;
   logic [CSR_DW-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                sop_q, sop_d;
   logic                eop_q, eop_d;
   logic [BYTES_W-1:0]  bytes_q, bytes_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic [CSR_AW-1:0]   addr_q, addr_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic [CSR_DW-1:0]   wdata_q, wdata_d;
   logic                busy_q, busy_d;
   logic                poll_hit_c;
   logic [LEN_W-1:0]    len_c;

   assign poll_hit_c = (POLL_DIV != 0) && (poll_q == POLL_W'(POLL_DIV - 1));
   assign len_c      = csr_readdata[LEN_W-1:0];

   // Next-state and datapath; CSR strobes are decoded from the next state so
   // they are registered and coincide exactly with the *_RD / DONE states.
   always_comb begin
      state_d      = state_q;
      poll_d       = poll_q;
      words_left_d = words_left_q;
      last_bytes_d = last_bytes_q;
      first_d      = first_q;
      data_d       = data_q;
      valid_d      = valid_q;
      sop_d        = sop_q;
      eop_d        = eop_q;
      bytes_d      = bytes_q;

      case (state_q)
         S_IDLE: begin
            if (enable && (irq || poll_hit_c)) begin
               state_d = S_ST_RD;
               poll_d  = '0;
            end else begin
               poll_d  = poll_hit_c ? '0 : poll_q + POLL_W'(1);
            end
         end
         S_ST_RD:  state_d = S_ST_WT;
         S_ST_WT:  state_d = csr_readdata[PEND_BIT] ? S_LEN_RD : S_IDLE;
         S_LEN_RD: state_d = S_LEN_WT;
         S_LEN_WT: begin
            words_left_d = words_of(len_c);
            last_bytes_d = last_bytes(len_c);
            first_d      = 1'b1;
            state_d      = (len_c == '0) ? S_DONE : S_DAT_RD;
         end
         S_DAT_RD: state_d = S_DAT_WT;
         S_DAT_WT: begin
            data_d  = csr_readdata;
            valid_d = 1'b1;
            sop_d   = first_q;
            eop_d   = (words_left_q == WCNT_W'(1));
            bytes_d = (words_left_q == WCNT_W'(1)) ? last_bytes_q : 3'd4;
            state_d = S_PUSH;
         end
         S_PUSH: begin
            // Hold the word until accepted; the next CSR read waits for this.
            if (out_ready) begin
               valid_d      = 1'b0;
               sop_d        = 1'b0;
               eop_d        = 1'b0;
               bytes_d      = '0;
               first_d      = 1'b0;
               words_left_d = words_left_q - WCNT_W'(1);
               state_d      = (words_left_q == WCNT_W'(1)) ? S_DONE : S_DAT_RD;
            end
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      fcnt_d  = (state_d == S_DONE) ? fcnt_q + FCNT_W'(1) : fcnt_q;
      rd_d    = (state_d == S_ST_RD) || (state_d == S_LEN_RD) || (state_d == S_DAT_RD);
      wr_d    = (state_d == S_DONE);
      wdata_d = (state_d == S_DONE) ? DONE_VAL : '0;
      busy_d  = (state_d != S_IDLE);
      case (state_d)
         S_ST_RD:  addr_d = ADDR_STATUS;
         S_LEN_RD: addr_d = ADDR_RX_LEN;
         S_DAT_RD: addr_d = ADDR_RX_DATA;
         S_DONE:   addr_d = ADDR_RX_CTRL;
         default:  addr_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         poll_q       <= '0;
         words_left_q <= '0;
         last_bytes_q <= '0;
         first_q      <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         sop_q        <= 1'b0;
         eop_q        <= 1'b0;
         bytes_q      <= '0;
         fcnt_q       <= '0;
         addr_q       <= '0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         poll_q       <= poll_d;
         words_left_q <= words_left_d;
         last_bytes_q <= last_bytes_d;
         first_q      <= first_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         sop_q        <= sop_d;
         eop_q        <= eop_d;
         bytes_q      <= bytes_d;
         fcnt_q       <= fcnt_d;
         addr_q       <= addr_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         wdata_q      <= wdata_d;
         busy_q       <= busy_d;
      end
   end

   assign csr_address   = addr_q;
   assign csr_read      = rd_q;
   assign csr_write     = wr_q;
   assign csr_writedata = wdata_q;
   assign out_data      = data_q;
   assign out_valid     = valid_q;
   assign out_sop       = sop_q;
   assign out_eop       = eop_q;
   assign out_bytes     = bytes_q;
   assign frame_cnt     = fcnt_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_cd_rx_drain.sv
// Directed bench for cd_rx_drain with a small cdbus CSR model on the far side.
module tb_cd_rx_drain;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable, irq, out_ready;
   logic [3:0]  csr_address;
   logic        csr_read, csr_write;
   logic [31:0] csr_readdata, csr_writedata, out_data;
   logic        out_valid, out_sop, out_eop, busy;
   logic [2:0]  out_bytes;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   cd_rx_drain #(.POLL_DIV(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .irq(irq),
      .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
      .csr_write(csr_write), .csr_writedata(csr_writedata),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sop(out_sop), .out_eop(out_eop), .out_bytes(out_bytes),
      .frame_cnt(frame_cnt), .busy(busy)
   );

   typedef struct {
      logic [31:0] d;
      logic        sop;
      logic        eop;
      logic [2:0]  b;
   } word_t;

   word_t       q[$];
   logic [31:0] mem [64];
   logic        pending = 1'b0;
   int          len_m = 0;
   int          ptr = 0;
   int          writes = 0, bad_writes = 0, stat_reads = 0, proto_err = 0;
   int          cyc = 0, first_stat = -1;
   int          checks = 0, errors = 0;

   // Free-running cycle count since reset release.
   always @(posedge clk) begin
      if (reset) cyc = 0;
      else       cyc = cyc + 1;
   end

   // cdbus CSR model and stream monitor, evaluated mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         first_stat = -1;
      end else begin
         if (csr_read && csr_write) proto_err++;
         if (csr_read) begin
            case (csr_address)
               4'd2: begin
                  csr_readdata = pending ? 32'h0000_0002 : 32'hFFFF_FFFD;
                  stat_reads++;
                  if (first_stat < 0) first_stat = cyc;
               end
               4'd6: csr_readdata = {24'hABCDEF, 8'(len_m)};
               4'd7: begin
                  csr_readdata = mem[ptr[5:0]];
                  ptr++;
               end
               default: csr_readdata = 32'hDEAD_BEEF;
            endcase
         end
         if (csr_write) begin
            if (csr_address == 4'd8 && csr_writedata == 32'h2) begin
               writes++;
               pending = 1'b0;
               ptr = 0;
            end else begin
               bad_writes++;
            end
         end
         if (out_valid && out_ready)
            q.push_back('{d: out_data, sop: out_sop, eop: out_eop, b: out_bytes});
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_frames(input string tag, input int target, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_cnt != 16'(target) && n < budget);
      check(tag, 32'(frame_cnt), 32'(target));
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 300);
      check(tag, 32'(out_valid), 32'd1);
   endtask

   task automatic start_frame(input int len);
      @(posedge clk); #1;
      len_m   = len;
      pending = 1'b1;
      irq     = 1'b1;
   endtask

   initial begin
      int bad, sr, n;
      enable = 1'b0; irq = 1'b0; out_ready = 1'b1; csr_readdata = '0;
      for (int i = 0; i < 64; i++) mem[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_csr_read",  32'(csr_read), 0);
      check("rst_csr_write", 32'(csr_write), 0);
      check("rst_csr_addr",  32'(csr_address), 0);
      check("rst_wdata",     csr_writedata, 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data",  out_data, 0);
      check("rst_flags",     {27'd0, out_sop, out_eop, out_bytes}, 0);
      check("rst_frame_cnt", 32'(frame_cnt), 0);
      check("rst_busy",      32'(busy), 0);
      @(posedge clk); #1;
      reset = 1'b0; enable = 1'b1;

      // Spurious irq with nothing pending
      repeat (2) @(posedge clk); #1;
      irq = 1'b1;
      @(posedge clk); #1;
      irq = 1'b0;
      repeat (10) @(negedge clk);
      check("spur_stat_read", 32'(stat_reads != 0), 1);
      check("spur_no_words",  32'(q.size()), 0);
      check("spur_no_write",  32'(writes + bad_writes), 0);
      check("spur_frame_cnt", 32'(frame_cnt), 0);
      check("spur_idle",      32'(busy), 0);

      // len=5, two words
      mem[0] = 32'h44332211; mem[1] = 32'h0000_0055;
      start_frame(5);
      wait_frames("f5_done", 1, 400);
      irq = 1'b0;
      check("f5_nwords", 32'(q.size()), 2);
      if (q.size() == 2) begin
         check("f5_w0_data", q[0].d, 32'h44332211);
         check("f5_w0_fl",   {27'd0, q[0].sop, q[0].eop, q[0].b}, {27'd0, 1'b1, 1'b0, 3'd4});
         check("f5_w1_data", q[1].d, 32'h55);
         check("f5_w1_fl",   {27'd0, q[1].sop, q[1].eop, q[1].b}, {27'd0, 1'b0, 1'b1, 3'd1});
      end
      check("f5_writes", 32'(writes), 1);

      // len=8 with consumer stalled on word 0
      q.delete();
      mem[0] = 32'h03020100; mem[1] = 32'h07060504;
      @(posedge clk); #1;
      out_ready = 1'b0;
      start_frame(8);
      wait_valid("stall_valid");
      for (int i = 0; i < 20; i++) begin
         check("stall_hold_valid", 32'(out_valid), 1);
         check("stall_hold_data",  out_data, 32'h03020100);
         check("stall_no_read",    32'(csr_read), 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_frames("f8_done", 2, 400);
      irq = 1'b0;
      check("f8_nwords", 32'(q.size()), 2);
      if (q.size() == 2) begin
         check("f8_w0_fl",   {27'd0, q[0].sop, q[0].eop, q[0].b}, {27'd0, 1'b1, 1'b0, 3'd4});
         check("f8_w1_data", q[1].d, 32'h07060504);
         check("f8_w1_fl",   {27'd0, q[1].sop, q[1].eop, q[1].b}, {27'd0, 1'b0, 1'b1, 3'd4});
      end

      // len=0: release only
      q.delete();
      start_frame(0);
      wait_frames("f0_done", 3, 400);
      irq = 1'b0;
      check("f0_nwords", 32'(q.size()), 0);
      check("f0_writes", 32'(writes), 3);

      // len=255: 64 words, last carries 3 bytes
      q.delete();
      for (int i = 0; i < 64; i++) mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      start_frame(255);
      wait_frames("f255_done", 4, 1000);
      irq = 1'b0;
      check("f255_nwords", 32'(q.size()), 64);
      bad = 0;
      if (q.size() == 64) begin
         for (int i = 0; i < 64; i++) begin
            if (q[i].d !== mem[i] || q[i].sop !== (i == 0) || q[i].eop !== (i == 63) ||
                q[i].b !== ((i == 63) ? 3'd3 : 3'd4)) bad++;
         end
         check("f255_last_bytes", 32'(q[63].b), 3);
      end
      check("f255_bad_words", 32'(bad), 0);

      // enable dropped mid-frame: frame finishes, then stays idle with irq high
      q.delete();
      mem[0] = 32'hA0A1A2A3; mem[1] = 32'hB0B1B2B3; mem[2] = 32'hC0C1C2C3;
      start_frame(12);
      wait_valid("en_valid");
      @(posedge clk); #1;
      enable = 1'b0;
      wait_frames("en_done", 5, 400);
      sr = stat_reads;
      repeat (40) @(negedge clk);
      check("en_idle",     32'(busy), 0);
      check("en_no_poll",  32'(stat_reads - sr), 0);
      check("en_nwords",   32'(q.size()), 3);
      if (q.size() == 3) check("en_w2_data", q[2].d, 32'hC0C1C2C3);
      irq = 1'b0;
      enable = 1'b1;

      // Reset during DAT_WT of word 3
      for (int i = 0; i < 5; i++) mem[i] = 32'h1000 + 32'(i);
      start_frame(20);
      n = 0;
      for (int k = 0; k < 400 && n < 4; k++) begin
         @(negedge clk);
         if (csr_read && csr_address == 4'd7) n++;
      end
      check("mid_data_reads", 32'(n), 4);
      @(posedge clk); #1;
      reset = 1'b1;
      irq = 1'b0; pending = 1'b0; ptr = 0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_busy",  32'(busy), 0);
      check("mid_rst_csr",   {26'd0, csr_read, csr_write, csr_address}, 0);
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_data",  out_data, 0);
      check("mid_rst_fcnt",  32'(frame_cnt), 0);

      // Polling only: pending appears at clk 5, status read lands at clk 16
      q.delete();
      mem[0] = 32'hCAFEF00D;
      len_m = 4;
      @(posedge clk); #1;
      reset = 1'b0;
      while (cyc < 5) begin
         @(posedge clk); #1;
      end
      pending = 1'b1;
      wait_frames("poll_done", 1, 200);
      check("poll_first_stat", 32'(first_stat), 16);
      check("poll_nwords", 32'(q.size()), 1);
      if (q.size() == 1) begin
         check("poll_w0_data", q[0].d, 32'hCAFEF00D);
         check("poll_w0_fl",   {27'd0, q[0].sop, q[0].eop, q[0].b}, {27'd0, 1'b1, 1'b1, 3'd4});
      end

      check("bad_writes", 32'(bad_writes), 0);
      check("rd_wr_overlap", 32'(proto_err), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
